// File: rtl/output_scan_pkg.sv
// Shared definitions for the output-unit RAM scanner: FSM state encoding
// and default geometry of the 16x8 output-unit RAM.
package output_scan_pkg;

    localparam int DEFAULT_NUM_OUTPUTS = 10;
    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_ADDR_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational argmax step: folds one new (index, value) pair into the
// running maximum. The first entry always loads; later entries replace the
// running maximum only when strictly greater, so ties keep the lowest index.
module argmax_cmp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic [DATA_W-1:0] cur_max,
    input  logic [ADDR_W-1:0] cur_idx,
    input  logic [DATA_W-1:0] new_val,
    input  logic [ADDR_W-1:0] new_idx,
    input  logic              first,
    output logic [DATA_W-1:0] next_max,
    output logic [ADDR_W-1:0] next_idx
);

    logic take;

    assign take     = first || (new_val > cur_max);
    assign next_max = take ? new_val : cur_max;
    assign next_idx = take ? new_idx : cur_idx;

endmodule

// File: rtl/output_unit_scanner.sv
// Output-unit scanner: reads entries 0..NUM_OUTPUTS-1 of the output-unit RAM
// through its registered-address read port and reports the index and value
// of the largest entry.
// Optional feature macro: SCANNER_STREAM_EN adds a per-entry stream of
// (index, value) beats, one cycle after each entry is compared.
module output_unit_scanner
    import output_scan_pkg::*;
#(
    parameter int NUM_OUTPUTS = DEFAULT_NUM_OUTPUTS,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] digit,
`ifdef SCANNER_STREAM_EN
    output logic              stream_valid,
    output logic [ADDR_W-1:0] stream_idx,
    output logic [DATA_W-1:0] stream_data,
`endif
    output logic [DATA_W-1:0] max_val
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUTPUTS - 1);
    // Address presented after PRIME; a single-entry scan never leaves 0.
    localparam logic [ADDR_W-1:0] FIRST_RD = (NUM_OUTPUTS > 1) ? ADDR_W'(1) : '0;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cmp_idx;
    logic [ADDR_W-1:0] run_idx;
    logic [DATA_W-1:0] run_max;
    logic [ADDR_W-1:0] next_idx;
    logic [DATA_W-1:0] next_max;

    argmax_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_argmax_cmp (
        .cur_max  (run_max),
        .cur_idx  (run_idx),
        .new_val  (ram_q),
        .new_idx  (cmp_idx),
        .first    (cmp_idx == '0),
        .next_max (next_max),
        .next_idx (next_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PRIME;
            PRIME:   state_next = SCAN;
            SCAN:    if (cmp_idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == PRIME) || (state == SCAN);
    assign done = (state == DONE);

    // Read address, compare index, running max and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            cmp_idx  <= '0;
            run_idx  <= '0;
            run_max  <= '0;
            digit    <= '0;
            max_val  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_addr <= '0;
                    if (start) begin
                        cmp_idx <= '0;
                        digit   <= '0;
                        max_val <= '0;
                    end
                end
                PRIME: begin
                    ram_addr <= FIRST_RD;
                    cmp_idx  <= '0;
                end
                SCAN: begin
                    run_max <= next_max;
                    run_idx <= next_idx;
                    cmp_idx <= cmp_idx + ADDR_W'(1);
                    // Saturate at the last entry; the RAM is never asked
                    // for anything beyond the scanned range.
                    if (ram_addr < LAST_IDX) ram_addr <= ram_addr + ADDR_W'(1);
                    if (cmp_idx == LAST_IDX) begin
                        digit   <= next_idx;
                        max_val <= next_max;
                    end
                end
                DONE:    ram_addr <= '0;
                default: ram_addr <= '0;
            endcase
        end
    end

`ifdef SCANNER_STREAM_EN
    // One beat per compared entry, presented the cycle after its compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stream_valid <= 1'b0;
            stream_idx   <= '0;
            stream_data  <= '0;
        end else begin
            stream_valid <= (state == SCAN);
            stream_idx   <= cmp_idx;
            stream_data  <= ram_q;
        end
    end
`endif

endmodule

// File: tb/tb_output_unit_scanner.sv
// Directed testbench for output_unit_scanner with a registered-address RAM
// model. Define SCANNER_STREAM_EN to also check the per-entry stream.
module tb_output_unit_scanner;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ram_addr;
    logic [7:0] ram_q;
    logic       busy;
    logic       done;
    logic [3:0] digit;
    logic [7:0] max_val;
`ifdef SCANNER_STREAM_EN
    logic       stream_valid;
    logic [3:0] stream_idx;
    logic [7:0] stream_data;
`endif

    logic [7:0] mem [16];
    int vectors     = 0;
    int miscompares = 0;

    output_unit_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ram_addr     (ram_addr),
        .ram_q        (ram_q),
        .busy         (busy),
        .done         (done),
        .digit        (digit),
`ifdef SCANNER_STREAM_EN
        .stream_valid (stream_valid),
        .stream_idx   (stream_idx),
        .stream_data  (stream_data),
`endif
        .max_val      (max_val)
    );

    always #5 clk = ~clk;

    // Output-unit RAM model: data reflects the address of the previous edge.
    always @(posedge clk) ram_q <= mem[ram_addr];

    // Entries past the scanned range are larger than most test data, so an
    // overscan shows up in the result.
    task automatic load_mem(input logic [7:0] v [10]);
        for (int i = 0; i < 16; i++) mem[i] = (i < N) ? v[i] : 8'hEE;
    endtask

    task automatic do_scan(input string name, input logic [3:0] exp_digit,
                           input logic [7:0] exp_max);
        int edges;
        int max_addr;
        int beats;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        vectors++;
        if ({digit, max_val} !== 12'h000) begin
            miscompares++;
            $display("FAIL %s cleared_on_start: got %h/%h want 0/00", name, digit, max_val);
        end
        edges = 0;
        max_addr = int'(ram_addr);
        beats = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
`ifdef SCANNER_STREAM_EN
            if (stream_valid === 1'b1) begin
                vectors++;
                if (beats < 16 && ({stream_idx, stream_data} !== {4'(beats), mem[beats]})) begin
                    miscompares++;
                    $display("FAIL %s stream_beat%0d: got %h/%h want %h/%h", name, beats,
                             stream_idx, stream_data, 4'(beats), mem[beats]);
                end
                beats++;
            end
`endif
        end
        vectors++;
        if (edges !== 11) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d edges want 11", name, edges);
        end
        vectors++;
        if (digit !== exp_digit) begin
            miscompares++;
            $display("FAIL %s digit: got %0d want %0d", name, digit, exp_digit);
        end
        vectors++;
        if (max_val !== exp_max) begin
            miscompares++;
            $display("FAIL %s max_val: got %h want %h", name, max_val, exp_max);
        end
        vectors++;
        if (max_addr !== N - 1) begin
            miscompares++;
            $display("FAIL %s max_ram_addr: got %0d want %0d", name, max_addr, N - 1);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        end
`ifdef SCANNER_STREAM_EN
        vectors++;
        if (beats !== N || stream_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s stream_count_last: got %0d beats valid=%b want %0d beats valid=1",
                     name, beats, stream_valid, N);
        end
`endif
        @(posedge clk); #1;
        vectors++;
        if ({done, busy, ram_addr} !== 6'b00_0000) begin
            miscompares++;
            $display("FAIL %s after_done: got done=%b busy=%b addr=%0d want 0/0/0",
                     name, done, busy, ram_addr);
        end
        @(posedge clk); #1;
        vectors++;
        if ({digit, max_val} !== {exp_digit, exp_max}) begin
            miscompares++;
            $display("FAIL %s result_hold: got %h/%h want %h/%h", name, digit, max_val,
                     exp_digit, exp_max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ram_addr, busy, done, digit, max_val} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%0d busy=%b done=%b digit=%0d max=%h want all 0",
                     ram_addr, busy, done, digit, max_val);
        end
`ifdef SCANNER_STREAM_EN
        vectors++;
        if (stream_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stream_valid: got %b want 0", stream_valid);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_mem('{8'h03, 8'h10, 8'h7F, 8'h22, 8'h00, 8'h05, 8'h7E, 8'h11, 8'h01, 8'h02});
        do_scan("basic", 4'd2, 8'h7F);
    endtask

    task automatic test_all_zero();
        load_mem('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        do_scan("all_zero", 4'd0, 8'h00);
    endtask

    task automatic test_tie();
        load_mem('{8'h01, 8'h01, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h01});
        do_scan("tie", 4'd3, 8'hFF);
    endtask

    task automatic test_max_last();
        load_mem('{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF});
        do_scan("max_last", 4'd9, 8'hFF);
    endtask

    task automatic test_held_start();
        int   dones;
        logic prev_done;
        load_mem('{8'h03, 8'h10, 8'h7F, 8'h22, 8'h00, 8'h05, 8'h7E, 8'h11, 8'h01, 8'h02});
        dones = 0;
        prev_done = 1'b0;
        start = 1'b1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (e == 29) start = 1'b0;
            if (prev_done) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL held_idle_gap: got busy=%b want 0 at edge %0d", busy, e);
                end
            end
            if (done === 1'b1) begin
                dones++;
                vectors++;
                if ({digit, max_val} !== {4'd2, 8'h7F}) begin
                    miscompares++;
                    $display("FAIL held_result%0d: got %h/%h want 2/7f", dones, digit, max_val);
                end
            end
            prev_done = done;
        end
        vectors++;
        if (dones !== 3) begin
            miscompares++;
            $display("FAIL held_done_count: got %0d want 3", dones);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dones;
        load_mem('{8'h03, 8'h10, 8'h7F, 8'h22, 8'h00, 8'h05, 8'h7E, 8'h11, 8'h01, 8'h02});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({busy, ram_addr} !== {1'b1, 4'd4}) begin
            miscompares++;
            $display("FAIL midscan_state: got busy=%b addr=%0d want 1/4", busy, ram_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({ram_addr, busy, done, digit, max_val} !== 18'h0) begin
            miscompares++;
            $display("FAIL midscan_reset_outputs: got addr=%0d busy=%b done=%b digit=%0d max=%h want 0",
                     ram_addr, busy, done, digit, max_val);
        end
`ifdef SCANNER_STREAM_EN
        vectors++;
        if (stream_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midscan_reset_stream: got %b want 0", stream_valid);
        end
`endif
        dones = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL midscan_no_done: got %0d active cycles want 0", dones);
        end
        load_mem('{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF});
        do_scan("after_reset", 4'd9, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_tie();
        test_max_last();
        test_held_start();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
